// File: rtl/numerator_entry_ctrl_pkg.sv
// numerator_entry_ctrl_pkg: Numerator field selects, keypad codes and digit-key helper
package numerator_entry_ctrl_pkg;
  localparam logic [2:0] SL_A = 3'd1;
  localparam logic [2:0] SL_B = 3'd2;
  localparam logic [4:0] KEY_0 = 5'd0;
  localparam logic [4:0] KEY_1 = 5'd1;
  localparam logic [4:0] KEY_2 = 5'd2;
  localparam logic [4:0] KEY_3 = 5'd3;
  localparam logic [4:0] KEY_4 = 5'd4;
  localparam logic [4:0] KEY_5 = 5'd5;
  localparam logic [4:0] KEY_6 = 5'd6;
  localparam logic [4:0] KEY_7 = 5'd7;
  localparam logic [4:0] KEY_8 = 5'd8;
  localparam logic [4:0] KEY_9 = 5'd9;
  localparam logic [4:0] KEY_ENT = 5'd10;
  localparam logic [4:0] KEY_CLR = 5'd11;
  localparam logic [4:0] KEY_BSP = 5'd12;
  function automatic logic is_digit(input logic [4:0] k);
    return k <= KEY_9;
  endfunction
endpackage

// File: rtl/numerator_entry_ctrl_timer.sv
// entry_timeout_timer: idle-cycle counter; clr zeroes, run counts, expired pulses on the last idle cycle
module entry_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  // a clear in the same cycle wins, so a key on the final cycle suppresses expiry
  assign expired = run && !clr && cnt == TO_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : run ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/numerator_entry_ctrl.sv
// numerator_entry_ctrl: sequences keypad strobes into Numerator write cycles for field A or B
//   in : clk, rst (async, active-high), start, field_sel, key_valid, key_code[4:0]
//   out: index[1:0], enabled, key[4:0], ST_L[2:0] (Numerator write port);
//        busy, digit_count[2:0], done, aborted (status)
module numerator_entry_ctrl
  import numerator_entry_ctrl_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       field_sel,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic [1:0] index,
  output logic       enabled,
  output logic [4:0] key,
  output logic [2:0] ST_L,
  output logic       busy,
  output logic [2:0] digit_count,
  output logic       done,
  output logic       aborted
);
  localparam logic [1:0] IDLE = 2'd0, ENTRY = 2'd1, WRITE = 2'd2, FULL = 2'd3;
  logic [1:0] state;
  logic run, clr, expired;
  assign busy = state != IDLE;
  assign run = state == ENTRY || state == FULL;
  // any strobe restarts the idle window; IDLE keeps the timer parked at zero
  assign clr = key_valid || state == IDLE;
  entry_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_timer (
    .clk(clk), .rst(rst), .clr(clr), .run(run), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      index <= '0;
      enabled <= 1'b0;
      key <= KEY_0;
      ST_L <= SL_A;
      digit_count <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      enabled <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= ENTRY;
            ST_L <= field_sel ? SL_B : SL_A;
            digit_count <= '0;
            index <= '0;
          end
        WRITE: begin
          digit_count <= digit_count + 3'd1;
          state <= (digit_count + 3'd1 == 3'(DIGITS)) ? FULL : ENTRY;
        end
        default:
          if (key_valid) begin
            if (state == ENTRY && is_digit(key_code)) begin
              key <= key_code;
              index <= digit_count[1:0];
              enabled <= 1'b1;
              state <= WRITE;
            end else if (key_code == KEY_CLR) begin
              digit_count <= '0;
              index <= '0;
              state <= ENTRY;
            end else if (key_code == KEY_BSP && digit_count != '0) begin
              digit_count <= digit_count - 3'd1;
              index <= 2'(digit_count - 3'd1);
              state <= ENTRY;
            end else if (state == FULL && key_code == KEY_ENT) begin
              done <= 1'b1;
              state <= IDLE;
            end
          end else if (expired) begin
            aborted <= 1'b1;
            digit_count <= '0;
            state <= IDLE;
          end
      endcase
    end
endmodule
